// File: rtl/reorder_buffer_if.sv
// Rename-side issue, completion broadcast, retire/free-list return and occupancy status of the reorder buffer.
interface reorder_buffer_if #(
  parameter int PTR_W  = 4,
  parameter int PHYS_W = 6,
  parameter int ARCH_W = 5
);
  logic              issue_valid;
  logic [PHYS_W-1:0] issue_phys_rd;
  logic [PHYS_W-1:0] issue_old_phys_rd;
  logic [ARCH_W-1:0] issue_arch_rd;
  logic              issue_ready;
  logic [PTR_W-1:0]  issue_rob_idx;
  logic              complete_valid;
  logic [PHYS_W-1:0] complete_phys_reg;
  logic              retire_valid;
  logic [PHYS_W-1:0] retire_phys_reg;
  logic [PHYS_W-1:0] retire_new_phys;
  logic [ARCH_W-1:0] retire_arch_reg;
  logic              rob_empty;
  logic              rob_full;
  logic [PTR_W:0]    rob_count;

  modport master (
    output issue_valid, issue_phys_rd, issue_old_phys_rd, issue_arch_rd,
    output complete_valid, complete_phys_reg,
    input  issue_ready, issue_rob_idx,
    input  retire_valid, retire_phys_reg, retire_new_phys, retire_arch_reg,
    input  rob_empty, rob_full, rob_count
  );

  modport slave (
    input  issue_valid, issue_phys_rd, issue_old_phys_rd, issue_arch_rd,
    input  complete_valid, complete_phys_reg,
    output issue_ready, issue_rob_idx,
    output retire_valid, retire_phys_reg, retire_new_phys, retire_arch_reg,
    output rob_empty, rob_full, rob_count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retire buffer returning old physical tags to the free list; retire pulse 2 edges after completion (1 with ROB_COMPLETE_BYPASS_EN).
// Issue backpressure: issue_ready low whenever full, with no same-edge reuse of a slot freed by retire.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int PHYS_W = 6,
  parameter int ARCH_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  reorder_buffer_if.slave rob_if
);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [PHYS_W-1:0] phys_rd;
    logic [PHYS_W-1:0] old_phys_rd;
    logic [ARCH_W-1:0] arch_rd;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           ent [DEPTH];
  entry_t           head_ent;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             head_cmpl;
  logic             do_retire;
  logic             do_issue;

  assign head_ent = ent[head];

`ifdef ROB_COMPLETE_BYPASS_EN
  // A broadcast hitting the head this edge retires it immediately.
  assign head_cmpl = head_ent.done ||
                     (rob_if.complete_valid && (rob_if.complete_phys_reg == head_ent.phys_rd));
`else
  assign head_cmpl = head_ent.done;
`endif

  assign do_retire = head_ent.valid && head_cmpl;
  assign do_issue  = rob_if.issue_valid && rob_if.issue_ready;

  assign rob_if.issue_ready   = (count != FULL_CNT);
  assign rob_if.issue_rob_idx = tail;
  assign rob_if.rob_empty     = (count == '0);
  assign rob_if.rob_full      = (count == FULL_CNT);
  assign rob_if.rob_count     = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head                   <= '0;
      tail                   <= '0;
      count                  <= '0;
      rob_if.retire_valid    <= 1'b0;
      rob_if.retire_phys_reg <= '0;
      rob_if.retire_new_phys <= '0;
      rob_if.retire_arch_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rob_if.complete_valid && ent[i].valid && !ent[i].done &&
            (ent[i].phys_rd == rob_if.complete_phys_reg)) begin
          ent[i].done <= 1'b1;
        end
      end

      // Retire and issue never touch the same slot: the tail slot is free whenever issue is allowed.
      rob_if.retire_valid <= do_retire;
      if (do_retire) begin
        ent[head].valid        <= 1'b0;
        ent[head].done         <= 1'b0;
        head                   <= head + 1'b1;
        rob_if.retire_phys_reg <= head_ent.old_phys_rd;
        rob_if.retire_new_phys <= head_ent.phys_rd;
        rob_if.retire_arch_reg <= head_ent.arch_rd;
      end

      if (do_issue) begin
        ent[tail].valid       <= 1'b1;
        ent[tail].done        <= 1'b0;
        ent[tail].phys_rd     <= rob_if.issue_phys_rd;
        ent[tail].old_phys_rd <= rob_if.issue_old_phys_rd;
        ent[tail].arch_rd     <= rob_if.issue_arch_rd;
        tail                  <= tail + 1'b1;
      end

      case ({do_issue, do_retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised and directed bench for reorder_buffer, checked against a program-order queue model.
module tb_reorder_buffer;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int PHYS_W = 6;
  localparam int ARCH_W = 5;
`ifdef ROB_COMPLETE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  reorder_buffer_if #(.PTR_W(PTR_W), .PHYS_W(PHYS_W), .ARCH_W(ARCH_W)) rif ();

  reorder_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PHYS_W(PHYS_W), .ARCH_W(ARCH_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rob_if (rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] phys;
    logic [5:0] old;
    logic [4:0] arch;
    bit         done;
  } m_ent_t;

  m_ent_t     mq[$];
  int         m_tail;
  logic       e_rv;
  logic [5:0] e_rp;
  logic [5:0] e_rn;
  logic [4:0] e_ra;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    e_rv = 1'b0;
    e_rp = '0;
    e_rn = '0;
    e_ra = '0;
  endtask

  function automatic int oldest_pending();
    foreach (mq[i]) if (!mq[i].done) return i;
    return -1;
  endfunction

  // Drive one cycle and advance the program-order model by one edge.
  task automatic cycle(input bit iv, input logic [5:0] p, input logic [5:0] o, input logic [4:0] a,
                       input bit cv, input logic [5:0] ct);
    bit rdy;
    bit ret;
    rif.issue_valid       = iv;
    rif.issue_phys_rd     = p;
    rif.issue_old_phys_rd = o;
    rif.issue_arch_rd     = a;
    rif.complete_valid    = cv;
    rif.complete_phys_reg = ct;
    rdy = (mq.size() < DEPTH);
    ret = 1'b0;
    if (mq.size() > 0) ret = mq[0].done || (BYP && cv && (ct == mq[0].phys));
    if (cv) foreach (mq[i]) if (!mq[i].done && (mq[i].phys == ct)) mq[i].done = 1'b1;
    e_rv = ret;
    if (ret) begin
      e_rp = mq[0].old;
      e_rn = mq[0].phys;
      e_ra = mq[0].arch;
      void'(mq.pop_front());
    end
    if (iv && rdy) begin
      mq.push_back('{p, o, a, 1'b0});
      m_tail = (m_tail + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int pend;
    for (int c = 0; c < 80 && mq.size() > 0; c++) begin
      pend = oldest_pending();
      if (pend >= 0) cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b1, mq[pend].phys);
      else           cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 6'd0);
      n_checks++;
      if (rif.retire_valid !== e_rv || (e_rv && rif.retire_phys_reg !== e_rp))
        $display("FAIL %s_drain_retire got rv=%b old=%0d exp rv=%b old=%0d", name, rif.retire_valid, rif.retire_phys_reg, e_rv, e_rp);
      else n_pass++;
    end
    cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 6'd0);
    n_checks++;
    if (rif.rob_empty !== 1'b1 || rif.rob_count !== 5'd0 || mq.size() != 0)
      $display("FAIL %s_drain_empty got empty=%b count=%0d model=%0d exp 1 0 0", name, rif.rob_empty, rif.rob_count, mq.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rif.issue_valid = 1'b0; rif.issue_phys_rd = '0; rif.issue_old_phys_rd = '0; rif.issue_arch_rd = '0;
    rif.complete_valid = 1'b0; rif.complete_phys_reg = '0;
    reset_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (rif.retire_phys_reg !== 6'd0 || rif.retire_new_phys !== 6'd0 || rif.retire_arch_reg !== 5'd0 || rif.issue_rob_idx !== 4'd0)
      $display("FAIL reset_fields got %0d %0d %0d idx=%0d exp 0 0 0 0", rif.retire_phys_reg, rif.retire_new_phys, rif.retire_arch_reg, rif.issue_rob_idx);
    else n_pass++;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 6'd0);
      n_checks++;
      if (rif.rob_empty !== 1'b1 || rif.issue_ready !== 1'b1 || rif.rob_count !== 5'd0 || rif.retire_valid !== 1'b0 || rif.rob_full !== 1'b0)
        $display("FAIL reset_idle cyc=%0d got empty=%b ready=%b count=%0d rv=%b full=%b exp 1 1 0 0 0",
                 c, rif.rob_empty, rif.issue_ready, rif.rob_count, rif.retire_valid, rif.rob_full);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    cycle(1'b1, 6'd32, 6'd5, 5'd5, 1'b0, 6'd0);
    n_checks++;
    if (rif.rob_count !== 5'd1 || rif.retire_valid !== 1'b0)
      $display("FAIL single_issue got count=%0d rv=%b exp 1 0", rif.rob_count, rif.retire_valid);
    else n_pass++;
    cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b1, 6'd32);
    pulses += int'(rif.retire_valid);
    n_checks++;
    if (rif.retire_valid !== BYP) $display("FAIL single_lat_edge1 got rv=%b exp %b", rif.retire_valid, BYP);
    else n_pass++;
    cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 6'd0);
    pulses += int'(rif.retire_valid);
    n_checks++;
    if (rif.retire_valid !== (1'b1 ^ BYP)) $display("FAIL single_lat_edge2 got rv=%b exp %b", rif.retire_valid, 1'b1 ^ BYP);
    else n_pass++;
    n_checks++;
    if (rif.retire_phys_reg !== 6'd5 || rif.retire_new_phys !== 6'd32 || rif.retire_arch_reg !== 5'd5)
      $display("FAIL single_fields got old=%0d new=%0d arch=%0d exp 5 32 5", rif.retire_phys_reg, rif.retire_new_phys, rif.retire_arch_reg);
    else n_pass++;
    repeat (2) begin
      cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 6'd0);
      pulses += int'(rif.retire_valid);
    end
    n_checks++;
    if (pulses != 1 || rif.rob_count !== 5'd0)
      $display("FAIL single_once got pulses=%0d count=%0d exp 1 0", pulses, rif.rob_count);
    else n_pass++;
  endtask

  task automatic test_ooo();
    int pulses = 0;
    int got[$];
    int when[$];
    cycle(1'b1, 6'd33, 6'd10, 5'd1, 1'b0, 6'd0);
    cycle(1'b1, 6'd34, 6'd11, 5'd2, 1'b0, 6'd0);
    cycle(1'b1, 6'd35, 6'd12, 5'd3, 1'b0, 6'd0);
    cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b1, 6'd35);
    pulses += int'(rif.retire_valid);
    cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b1, 6'd34);
    pulses += int'(rif.retire_valid);
    cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b1, 6'd33);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 6'd0);
      if (rif.retire_valid === 1'b1) begin
        got.push_back(int'(rif.retire_phys_reg));
        when.push_back(c);
      end
    end
    n_checks++;
    if (pulses != 0) $display("FAIL ooo_early got pulses=%0d exp 0", pulses);
    else n_pass++;
    n_checks++;
    if (got.size() != 3) $display("FAIL ooo_count got %0d pulses exp 3", got.size());
    else if (got[0] != 10 || got[1] != 11 || got[2] != 12 || when[2] - when[0] != 2)
      $display("FAIL ooo_order got %0d,%0d,%0d span=%0d exp 10,11,12 span=2", got[0], got[1], got[2], when[2] - when[0]);
    else n_pass++;
    n_checks++;
    if (rif.rob_count !== 5'd0) $display("FAIL ooo_drained got count=%0d exp 0", rif.rob_count);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 6'(i), 6'(16 + i), 5'(i), 1'b0, 6'd0);
    n_checks++;
    if (rif.rob_full !== 1'b1 || rif.issue_ready !== 1'b0 || rif.rob_count !== 5'd16)
      $display("FAIL full_flags got full=%b ready=%b count=%0d exp 1 0 16", rif.rob_full, rif.issue_ready, rif.rob_count);
    else n_pass++;
    cycle(1'b1, 6'd20, 6'd30, 5'd0, 1'b0, 6'd0);
    n_checks++;
    if (rif.rob_count !== 5'd16 || rif.issue_rob_idx !== 4'(m_tail))
      $display("FAIL full_drop got count=%0d idx=%0d exp 16 %0d", rif.rob_count, rif.issue_rob_idx, m_tail);
    else n_pass++;
    // Keep issue_valid asserted through the freeing retire: it must still be dropped.
    cycle(1'b1, 6'd21, 6'd31, 5'd1, 1'b1, 6'd0);
    for (int k = 0; k < 6 && rif.retire_valid !== 1'b1; k++) cycle(1'b1, 6'd21, 6'd31, 5'd1, 1'b0, 6'd0);
    n_checks++;
    if (rif.retire_valid !== 1'b1) $display("FAIL full_retire_timeout got rv=%b exp 1", rif.retire_valid);
    else n_pass++;
    n_checks++;
    if (rif.retire_phys_reg !== 6'd16 || rif.rob_count !== 5'd15 || rif.issue_ready !== 1'b1)
      $display("FAIL full_free got old=%0d count=%0d ready=%b exp 16 15 1", rif.retire_phys_reg, rif.rob_count, rif.issue_ready);
    else n_pass++;
    drain("full");
  endtask

  task automatic test_steady();
    int pend;
    logic [5:0] tag;
    for (int i = 0; i < 8; i++) cycle(1'b1, 6'd50, 6'(i), 5'(i), 1'b0, 6'd0);
    cycle(BYP, 6'd60, 6'd8, 5'd8, 1'b1, 6'd50);
    for (int c = 0; c < 40; c++) begin
      tag = 6'(c % 48);
      pend = oldest_pending();
      if (pend >= 0) cycle(1'b1, tag, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), 1'b1, mq[pend].phys);
      else           cycle(1'b1, tag, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), 1'b0, 6'd0);
      n_checks++;
      if (rif.rob_count !== 5'd8 || rif.retire_valid !== 1'b1)
        $display("FAIL steady_count cyc=%0d got count=%0d rv=%b exp 8 1", c, rif.rob_count, rif.retire_valid);
      else n_pass++;
      n_checks++;
      if (rif.retire_phys_reg !== e_rp || rif.retire_new_phys !== e_rn || rif.issue_rob_idx !== 4'(m_tail))
        $display("FAIL steady_order cyc=%0d got old=%0d new=%0d idx=%0d exp %0d %0d %0d",
                 c, rif.retire_phys_reg, rif.retire_new_phys, rif.issue_rob_idx, e_rp, e_rn, m_tail);
      else n_pass++;
    end
    drain("steady");
  endtask

  task automatic test_random(input int n);
    bit iv, cv;
    logic [5:0] ct;
    for (int c = 0; c < n; c++) begin
      iv = (c < n / 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cv = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) ct = mq[$urandom_range(0, mq.size() - 1)].phys;
      else ct = 6'($urandom_range(0, 63));
      cycle(iv, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), cv, ct);
      n_checks++;
      if (rif.retire_valid !== e_rv || rif.retire_phys_reg !== e_rp || rif.retire_new_phys !== e_rn || rif.retire_arch_reg !== e_ra)
        $display("FAIL rand_retire cyc=%0d got rv=%b %0d/%0d/%0d exp rv=%b %0d/%0d/%0d", c, rif.retire_valid,
                 rif.retire_phys_reg, rif.retire_new_phys, rif.retire_arch_reg, e_rv, e_rp, e_rn, e_ra);
      else n_pass++;
      n_checks++;
      if (rif.rob_count !== 5'(mq.size()) || rif.issue_ready !== (mq.size() < DEPTH) ||
          rif.rob_full !== (mq.size() == DEPTH) || rif.rob_empty !== (mq.size() == 0))
        $display("FAIL rand_status cyc=%0d got count=%0d ready=%b full=%b empty=%b exp count=%0d",
                 c, rif.rob_count, rif.issue_ready, rif.rob_full, rif.rob_empty, mq.size());
      else n_pass++;
      n_checks++;
      if (rif.issue_rob_idx !== 4'(m_tail)) $display("FAIL rand_idx cyc=%0d got %0d exp %0d", c, rif.issue_rob_idx, m_tail);
      else n_pass++;
    end
    drain("rand");
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 6'(41 + i), 6'(1 + i), 5'(i), 1'b0, 6'd0);
    rif.issue_valid = 1'b0;
    rif.complete_valid = 1'b0;
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rif.rob_count !== 5'd0 || rif.rob_empty !== 1'b1 || rif.retire_valid !== 1'b0 || rif.issue_ready !== 1'b1 || rif.issue_rob_idx !== 4'd0)
      $display("FAIL midreset_state got count=%0d empty=%b rv=%b ready=%b idx=%0d exp 0 1 0 1 0",
               rif.rob_count, rif.rob_empty, rif.retire_valid, rif.issue_ready, rif.issue_rob_idx);
    else n_pass++;
    #1 reset_n = 1'b1;
    cycle(1'b1, 6'd40, 6'd7, 5'd3, 1'b0, 6'd0);
    cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b1, 6'd40);
    pulses += int'(rif.retire_valid);
    cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b1, 6'd41);
    pulses += int'(rif.retire_valid);
    repeat (3) begin
      cycle(1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 6'd0);
      pulses += int'(rif.retire_valid);
    end
    n_checks++;
    if (pulses != 1 || rif.retire_phys_reg !== 6'd7 || rif.retire_new_phys !== 6'd40)
      $display("FAIL midreset_retire got pulses=%0d old=%0d new=%0d exp 1 7 40", pulses, rif.retire_phys_reg, rif.retire_new_phys);
    else n_pass++;
    n_checks++;
    if (rif.rob_count !== 5'd0 || rif.rob_empty !== 1'b1)
      $display("FAIL midreset_empty got count=%0d empty=%b exp 0 1", rif.rob_count, rif.rob_empty);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ooo();
    test_full();
    test_steady();
    test_random(400);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order retirement buffer that sits downstream of the rename stage and closes the physical-register allocation loop.
- Each renamed instruction is enqueued with its new physical destination, its previous physical destination and its architectural destination.
- Completion broadcasts mark entries done by physical tag.
- The head retires in program order and returns the previous physical register to the rename free list through retire_valid/retire_phys_reg.

Parameters:
DEPTH, 16, number of entries; must be a power of two.
PTR_W, 4, log2(DEPTH).
PHYS_W, 6, physical register tag width.
ARCH_W, 5, architectural register index width.

Ports:
clk  input  1  clock; all state updates on posedge.
reset_n  input  1  asynchronous, active-low reset.
issue_valid  input  1  enqueue request from rename.
issue_phys_rd  input  PHYS_W  newly allocated physical destination.
issue_old_phys_rd  input  PHYS_W  previous mapping of the destination; freed at retire.
issue_arch_rd  input  ARCH_W  architectural destination.
issue_ready  output  1  high when not full; combinational from registered count.
issue_rob_idx  output  PTR_W  current tail index; the slot the next accepted issue writes.
complete_valid  input  1  completion broadcast.
complete_phys_reg  input  PHYS_W  tag of the completed result.
retire_valid  output  1  registered; one-cycle pulse per retired entry.
retire_phys_reg  output  PHYS_W  registered; old_phys_rd of the retired entry, to be freed.
retire_new_phys  output  PHYS_W  registered; phys_rd of the retired entry.
retire_arch_reg  output  ARCH_W  registered; arch_rd of the retired entry.
rob_empty  output  1  count == 0.
rob_full  output  1  count == DEPTH.
rob_count  output  PTR_W+1  occupancy.

Behaviour:
- Reset (asynchronous):
  - head = tail = 0, count = 0.
  - All entry valid and done bits cleared.
  - retire_valid = 0; retire_phys_reg, retire_new_phys and retire_arch_reg = 0.
  - Outputs: rob_empty = 1, rob_full = 0, issue_ready = 1.
  - Reset mid-operation discards all entries; no retire pulse is produced.
- Entry fields: valid, done, phys_rd, old_phys_rd, arch_rd.
- Issue: on a posedge with issue_valid && issue_ready:
  - entry[tail] is written with valid = 1, done = 0 and the three fields.
  - tail increments and wraps modulo DEPTH.
  - issue_valid while full is dropped; no state change.
- Complete: on a posedge with complete_valid, every entry with valid && !done && phys_rd == complete_phys_reg sets done = 1.
  - A tag with no match is ignored.
  - Completion never matches the entry being written on the same edge.
- Retire: at most one entry per cycle.
  - When entry[head] has valid && done at the posedge (state before this edge's completion updates):
    - clear entry[head].valid; head increments and wraps.
    - retire_valid = 1 for the following cycle; retire_* carry that entry's fields.
  - Otherwise retire_valid = 0 and retire_* hold their previous values.
- Latency:
  - Completion at edge N; retire evaluated at edge N+1; retire_valid is high in the cycle after N+1.
  - An empty ROB issued-and-completed entry therefore retires no earlier than 2 edges after issue.
- Count: +1 on issue only, −1 on retire only, unchanged when both occur on the same edge.
- Full case: issue_ready is low for the whole cycle even when a retire frees a slot on that edge. There is no same-cycle bypass.
- Wrap-around: pointers are PTR_W bits and wrap naturally. Full and empty are decided from count, never from pointer equality.
- Out-of-order completion: younger entries may be done while the head is not. They wait and then retire one per cycle in order.

Optional Feature:
ROB_COMPLETE_BYPASS_EN
- Defined: the retire check uses the head's done bit OR'd with (complete_valid && complete_phys_reg == head.phys_rd). A head completing at edge N retires at edge N, so retire_valid is high in the cycle after N.
- Undefined: one extra cycle, as specified under Latency.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then idle 3 cycles -> rob_empty=1, issue_ready=1, rob_count=0, retire_valid never asserted.
- Issue (phys 32, old 5, arch 5); complete tag 32 at the next edge -> one retire_valid pulse with retire_phys_reg=5, retire_new_phys=32, retire_arch_reg=5. Pulse comes 1 cycle after the completion edge with the bypass, 2 cycles without; rob_count returns to 0.
- Issue A(33), B(34), C(35); complete 35, 34, then 33 -> no retire until 33 completes, then three consecutive pulses freeing old tags in order A, B, C.
- Issue 16 entries without completion -> rob_full=1, issue_ready=0. A 17th issue_valid is dropped and rob_count stays 16. Complete the head -> after its retire, issue_ready=1.
- Hold count at 8 with a simultaneous issue and head retire every cycle for 40 cycles -> rob_count stays 8, head and tail wrap past 15 to 0, and retire order matches issue order.
- Assert reset_n low while 5 entries are pending, release, then issue (phys 40, old 7) and complete 40 -> a single retire with retire_phys_reg=7; no stale entries retire.
